// File: rtl/hs32_regfile_banked.sv
// Banked hs32 register file: two registered read ports, one write port, same-cycle bypass,
// post-reset clear sweep. Define HS32_REG_PARITY_EN to add per-entry even parity and perr/perr_inject.
module hs32_regfile_banked #(
    parameter int DATA_W    = 32,
    parameter int AW        = 4,
    parameter int BANK_BASE = 12,
    parameter int NBANKS    = 2,
    localparam int BW       = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              we,
    input  logic [AW-1:0]     wadr,
    input  logic [BW-1:0]     wbank,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [BW-1:0]     rbank,
    input  logic [AW-1:0]     radr1,
    output logic [DATA_W-1:0] dout1,
    input  logic [AW-1:0]     radr2,
    output logic [DATA_W-1:0] dout2
`ifdef HS32_REG_PARITY_EN
    ,
    output logic              perr,
    input  logic              perr_inject
`endif
);
    localparam int NREGS = 1 << AW;
    localparam int NBK   = NREGS - BANK_BASE;
    localparam int NPHYS = BANK_BASE + NBANKS * NBK;
    localparam int PW    = (NPHYS > 1) ? $clog2(NPHYS) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   clr_idx, clr_nxt;

    logic [DATA_W-1:0] mem [NPHYS];
`ifdef HS32_REG_PARITY_EN
    logic              par_mem [NPHYS];
    logic              wr_par;
`endif

    logic              wr_en;
    logic [PW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [PW-1:0]     p_w, p_1, p_2;
    logic              rd_go, byp1, byp2;

    // Out-of-range bank numbers fall back to bank 0.
    function automatic logic [PW-1:0] phys(input logic [AW-1:0] a, input logic [BW-1:0] b);
        int bi;
        int p;
        bi = (int'(b) >= NBANKS) ? 0 : int'(b);
        if (int'(a) < BANK_BASE)
            p = int'(a);
        else
            p = BANK_BASE + bi * NBK + (int'(a) - BANK_BASE);
        return PW'(p);
    endfunction

    assign p_w   = phys(wadr, wbank);
    assign p_1   = phys(radr1, rbank);
    assign p_2   = phys(radr2, rbank);
    assign ready = (state == RUN);
    assign rd_go = ready && re;
    assign byp1  = we && (p_1 == p_w);
    assign byp2  = we && (p_2 == p_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_idx;
        wr_en     = 1'b0;
        wr_idx    = p_w;
        wr_data   = din;
`ifdef HS32_REG_PARITY_EN
        wr_par    = (^din) ^ perr_inject;
`endif
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = clr_idx;
                wr_data = '0;
`ifdef HS32_REG_PARITY_EN
                wr_par  = 1'b0;
`endif
                if (clr_idx == PW'(NPHYS - 1)) begin
                    state_nxt = RUN;
                    clr_nxt   = '0;
                end else begin
                    clr_nxt = clr_idx + 1'b1;
                end
            end
            RUN: wr_en = we;
            default: state_nxt = CLEAR;
        endcase
    end

    // Array has no reset so it maps to plain RAM; gating with reset drops a write on the reset edge.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem[wr_idx]     <= wr_data;
`ifdef HS32_REG_PARITY_EN
            par_mem[wr_idx] <= wr_par;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout1 <= '0;
            dout2 <= '0;
`ifdef HS32_REG_PARITY_EN
            perr  <= 1'b0;
`endif
        end else if (rd_go) begin
            dout1 <= byp1 ? din : mem[p_1];
            dout2 <= byp2 ? din : mem[p_2];
`ifdef HS32_REG_PARITY_EN
            perr  <= (!byp1 && ((^mem[p_1]) != par_mem[p_1])) ||
                     (!byp2 && ((^mem[p_2]) != par_mem[p_2]));
`endif
        end
    end
endmodule

// File: tb/tb_hs32_regfile_banked.sv
// Directed self-checking bench for hs32_regfile_banked (default parameters, 20 physical entries).
module tb_hs32_regfile_banked;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        we;
    logic [3:0]  wadr;
    logic        wbank;
    logic [31:0] din;
    logic        re;
    logic        rbank;
    logic [3:0]  radr1;
    logic [31:0] dout1;
    logic [3:0]  radr2;
    logic [31:0] dout2;
`ifdef HS32_REG_PARITY_EN
    logic        perr;
    logic        perr_inject;
`endif

    int checks = 0;
    int errors = 0;
    int cycles;

    always #5 clk = ~clk;

    hs32_regfile_banked dut (
        .clk(clk), .reset(reset), .ready(ready),
        .we(we), .wadr(wadr), .wbank(wbank), .din(din),
        .re(re), .rbank(rbank),
        .radr1(radr1), .dout1(dout1),
        .radr2(radr2), .dout2(dout2)
`ifdef HS32_REG_PARITY_EN
        , .perr(perr), .perr_inject(perr_inject)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic b, input logic [31:0] d);
        we = 1'b1; wadr = a; wbank = b; din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2, input logic b);
        re = 1'b1; radr1 = a1; radr2 = a2; rbank = b;
        tick();
        re = 1'b0;
    endtask

    // Counts edges from reset release to ready; bounded so a stuck sweep still reaches the summary.
    task automatic wait_ready(input string tag);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
        chk(tag, cycles, 20);
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; wadr = '0; wbank = 1'b0; din = '0;
        re = 1'b0; rbank = 1'b0; radr1 = '0; radr2 = '0;
`ifdef HS32_REG_PARITY_EN
        perr_inject = 1'b0;
`endif
        tick(); tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_dout1", dout1, 32'd0);
        chk("reset_dout2", dout2, 32'd0);

        reset = 1'b1;
        wait_ready("sweep_len");

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) begin
                rd(4'(i), 4'(15 - i), b[0]);
                chk("clear_d1", dout1, 32'd0);
                chk("clear_d2", dout2, 32'd0);
            end

        wr(4'd3, 1'b0, 32'hDEADBEEF);
        rd(4'd3, 4'd0, 1'b1);
        chk("shared_r3", dout1, 32'hDEADBEEF);

        wr(4'd13, 1'b0, 32'h11111111);
        wr(4'd13, 1'b1, 32'h22222222);
        rd(4'd13, 4'd13, 1'b0);
        chk("bank0_r13", dout1, 32'h11111111);
        rd(4'd13, 4'd3, 1'b1);
        chk("bank1_r13", dout1, 32'h22222222);
        chk("port2_r3", dout2, 32'hDEADBEEF);
        rd(4'd12, 4'd15, 1'b1);
        chk("bank1_r12", dout1, 32'd0);

        // Bypass on port 1 only; port 2 sees stored r6.
        wr(4'd6, 1'b0, 32'h66666666);
        we = 1'b1; wadr = 4'd5; wbank = 1'b0; din = 32'hA5A5A5A5;
        re = 1'b1; radr1 = 4'd5; radr2 = 4'd6; rbank = 1'b0;
        tick();
        chk("byp_d1", dout1, 32'hA5A5A5A5);
        chk("byp_d2_old", dout2, 32'h66666666);
        we = 1'b0; re = 1'b0; radr1 = 4'd0; radr2 = 4'd1;
        tick();
        chk("hold_d1", dout1, 32'hA5A5A5A5);
        chk("hold_d2", dout2, 32'h66666666);
        rd(4'd5, 4'd5, 1'b1);
        chk("r5_stored", dout1, 32'hA5A5A5A5);

        we = 1'b1; wadr = 4'd6; wbank = 1'b0; din = 32'h12345678;
        re = 1'b1; radr1 = 4'd6; radr2 = 4'd6; rbank = 1'b1;
        tick();
        chk("byp_both_d1", dout1, 32'h12345678);
        chk("byp_both_d2", dout2, 32'h12345678);

        // Banked write with a read of the other bank must not bypass.
        we = 1'b1; wadr = 4'd13; wbank = 1'b1; din = 32'h33333333;
        re = 1'b1; radr1 = 4'd13; radr2 = 4'd14; rbank = 1'b0;
        tick();
        we = 1'b0; re = 1'b0;
        chk("nobyp_bank", dout1, 32'h11111111);
        rd(4'd13, 4'd13, 1'b1);
        chk("bank1_r13_new", dout1, 32'h33333333);

        // Reset mid-sweep; writes attempted throughout the sweep must be lost.
        reset = 1'b0;
        tick();
        chk("rst2_dout", dout1, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b0;
        #2;
        chk("async_ready", {31'd0, ready}, 32'd0);
        tick();
        we = 1'b1; wadr = 4'd3; wbank = 1'b0; din = 32'hFFFFFFFF;
        re = 1'b1; radr1 = 4'd3; radr2 = 4'd3; rbank = 1'b0;
        reset = 1'b1;
        wait_ready("sweep_restart");
        we = 1'b0; re = 1'b0;
        chk("clear_dout_held", dout1, 32'd0);
        rd(4'd3, 4'd13, 1'b1);
        chk("lost_wr_r3", dout1, 32'd0);
        chk("cleared_r13b1", dout2, 32'd0);

`ifdef HS32_REG_PARITY_EN
        chk("perr_clear", {31'd0, perr}, 32'd0);
        perr_inject = 1'b1;
        wr(4'd2, 1'b0, 32'h00000007);
        perr_inject = 1'b0;
        rd(4'd2, 4'd0, 1'b0);
        chk("perr_inj", {31'd0, perr}, 32'd1);
        chk("perr_data", dout1, 32'h00000007);
        wr(4'd2, 1'b0, 32'h00000007);
        rd(4'd2, 4'd0, 1'b0);
        chk("perr_clean", {31'd0, perr}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
